// File: rtl/run_seq_pkg.sv
// run_seq_pkg -- shared types and constants for the run sequencer.
//   seq_state_e   : sequencer FSM states
//   NPROG_DEF     : default number of programs
//   START_CYC_DEF : default cpu_start hold length per launch
//   BASE_TAB      : program start addresses, indexed by program number
//   base_addr()   : table lookup, returns 0 for an index past the table
package run_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_FIN
  } seq_state_e;

  localparam int NPROG_DEF     = 3;
  localparam int START_CYC_DEF = 2;

  localparam int unsigned BASE_TAB [NPROG_DEF] = '{0, 166, 236};

  function automatic int unsigned base_addr(input logic [1:0] idx);
    if (int'(idx) >= NPROG_DEF) return 0;
    return BASE_TAB[idx];
  endfunction

endpackage

// File: rtl/run_sequencer_counter.sv
// seq_counter -- saturating RUN-cycle counter.
//   clk, reset : rising-edge clock, synchronous active-low reset
//   clr        : zero the count (held while not running)
//   en         : count this cycle
//   tally      : count including the current cycle; this is the value
//                reported when a program finishes in this cycle
//   wd_hit     : (RUN_SEQ_WATCHDOG_EN only) tally has reached all-ones
// The count never wraps: once at all-ones it stays there.
module seq_counter #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [TMO_W-1:0] tally
`ifdef RUN_SEQ_WATCHDOG_EN
  ,
  output logic             wd_hit
`endif
);

  localparam logic [TMO_W-1:0] MAX = '1;

  logic [TMO_W-1:0] cnt;

  always_comb begin
    tally = cnt;
    if (en && cnt != MAX) tally = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset || clr) cnt <= '0;
    else               cnt <= tally;
  end

`ifdef RUN_SEQ_WATCHDOG_EN
  assign wd_hit = en && (tally == MAX);
`endif

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer -- launches one program, or all programs back to back, on a
// CPU and times each run.
//   clk, reset : rising-edge clock, synchronous active-low reset
//   go         : launch request, only looked at in IDLE
//   run_all    : with go: 1 = programs 0..NPROG-1, 0 = prog_sel only
//   prog_sel   : program index for single-run mode
//   cpu_done   : CPU finished flag
//   cpu_start  : holds the CPU in init (launch strobe, also high in reset)
//   pc_init    : start address of the current program while launching
//   cur_prog   : program being run
//   busy       : not IDLE
//   seq_done   : one-cycle pulse when the requested sequence ends
//   cycles     : RUN-cycle count of the last finished program
//   err        : sticky; illegal prog_sel or watchdog expiry
// Optional feature: define RUN_SEQ_WATCHDOG_EN to abort a program whose
// RUN-cycle count reaches all-ones without cpu_done.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int D         = 10,
  parameter int NPROG     = NPROG_DEF,
  parameter int START_CYC = START_CYC_DEF,
  parameter int TMO_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             run_all,
  input  logic [1:0]       prog_sel,
  input  logic             cpu_done,
  output logic             cpu_start,
  output logic [D-1:0]     pc_init,
  output logic [1:0]       cur_prog,
  output logic             busy,
  output logic             seq_done,
  output logic [TMO_W-1:0] cycles,
  output logic             err
);

  localparam logic [2:0] NPROG_W   = 3'(NPROG);
  localparam logic [1:0] LAST_PROG = 2'(NPROG - 1);
  localparam logic [3:0] LC_LAST   = 4'(START_CYC - 1);

  seq_state_e       state, state_nxt;
  logic [3:0]       lcnt;
  logic             run_first;   // first RUN cycle: cpu_done is still stale
  logic             all_mode;
  logic             hold;        // keeps cpu_start up through reset
  logic             run_en;
  logic [TMO_W-1:0] tally;
  logic             accept, illegal, load_cyc, wd_fire, adv, fin_set;
`ifdef RUN_SEQ_WATCHDOG_EN
  logic             wd_hit;
`endif

  assign run_en = (state == S_RUN);

  seq_counter #(.TMO_W(TMO_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (!run_en),
    .en    (run_en),
    .tally (tally)
`ifdef RUN_SEQ_WATCHDOG_EN
    ,
    .wd_hit(wd_hit)
`endif
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    illegal   = 1'b0;
    load_cyc  = 1'b0;
    wd_fire   = 1'b0;
    adv       = 1'b0;
    fin_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          accept = 1'b1;
          if (!run_all && {1'b0, prog_sel} >= NPROG_W) illegal = 1'b1;
          else                                         state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (lcnt == LC_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        // done is checked first so a coincident watchdog hit is not an error
        if (!run_first && cpu_done) begin
          load_cyc  = 1'b1;
          state_nxt = S_NEXT;
        end
`ifdef RUN_SEQ_WATCHDOG_EN
        else if (wd_hit) begin
          load_cyc  = 1'b1;
          wd_fire   = 1'b1;
          state_nxt = S_NEXT;
        end
`endif
      end
      S_NEXT: begin
        if (all_mode && cur_prog < LAST_PROG) begin
          adv       = 1'b1;
          state_nxt = S_LAUNCH;
        end else begin
          fin_set   = 1'b1;
          state_nxt = S_FIN;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      lcnt      <= '0;
      run_first <= 1'b0;
      cur_prog  <= '0;
      all_mode  <= 1'b0;
      cycles    <= '0;
      err       <= 1'b0;
      seq_done  <= 1'b0;
      hold      <= 1'b1;
    end else begin
      state     <= state_nxt;
      hold      <= 1'b0;
      lcnt      <= (state == S_LAUNCH) ? lcnt + 4'd1 : 4'd0;
      run_first <= (state == S_LAUNCH);
      seq_done  <= fin_set | illegal;
      if (accept) begin
        all_mode <= run_all;
        err      <= illegal;
        if (!illegal) cur_prog <= run_all ? 2'd0 : prog_sel;
      end
      if (adv)             cur_prog <= cur_prog + 2'd1;
      if (load_cyc)        cycles   <= tally;
      if (wd_fire)         err      <= 1'b1;
      if (state == S_FIN)  all_mode <= 1'b0;
    end
  end

  assign busy      = (state != S_IDLE);
  assign cpu_start = hold || (state == S_LAUNCH);
  assign pc_init   = (state == S_LAUNCH) ? D'(base_addr(cur_prog)) : '0;

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer -- self-checking bench for run_sequencer (TMO_W = 4 so
// counter saturation and the watchdog are reachable quickly).
// The reference model predicts, per program, the RUN cycle at which the run
// ends, the reported cycle count and the error flag, then checks the launch
// length, addresses and the cycle at which the next launch or seq_done shows.
module tb_run_sequencer;

  localparam int TMO   = 4;
  localparam int SAT   = 15;
  localparam int START = 2;
  localparam int NEVER = 1000;
  localparam int BUDGET = 60;

  logic       clk = 1'b0;
  logic       reset, go, run_all, cpu_done;
  logic [1:0] prog_sel;
  logic       cpu_start, busy, seq_done, err;
  logic [9:0] pc_init;
  logic [1:0] cur_prog;
  logic [TMO-1:0] cycles;

  int base_ref [3] = '{0, 166, 236};
  int n_cmp = 0;
  int n_bad = 0;

  run_sequencer #(.D(10), .NPROG(3), .START_CYC(START), .TMO_W(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .run_all  (run_all),
    .prog_sel (prog_sel),
    .cpu_done (cpu_done),
    .cpu_start(cpu_start),
    .pc_init  (pc_init),
    .cur_prog (cur_prog),
    .busy     (busy),
    .seq_done (seq_done),
    .cycles   (cycles),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_cpu_start"}, 32'(cpu_start), 1);
    chk({tag, "_pc_init"},   32'(pc_init),   0);
    chk({tag, "_cur_prog"},  32'(cur_prog),  0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_seq_done"},  32'(seq_done),  0);
    chk({tag, "_cycles"},    32'(cycles),    0);
    chk({tag, "_err"},       32'(err),       0);
  endtask

  task automatic do_reset(input string tag);
    go = 1'b0; cpu_done = 1'b0; reset = 1'b0;
    step();
    reset_checks(tag);
    step();
    chk({tag, "_hold"}, 32'(cpu_start), 1);
    reset = 1'b1;
    step();
    chk({tag, "_rel_start"}, 32'(cpu_start), 0);
    chk({tag, "_rel_busy"},  32'(busy), 0);
  endtask

  // One go request. dly[j]: RUN cycle in which cpu_done first shows for the
  // j-th program run (NEVER = not at all). hung reports that the DUT was left
  // busy and needs a reset.
  task automatic session(input bit ra, input logic [1:0] sel, input bit stale,
                         input int dly[3], input bit noise, output bit hung);
    int progs[$];
    int exp_err;
    hung = 1'b0;
    exp_err = 0;
    if (ra) progs = '{0, 1, 2};
    else    progs = '{int'(sel)};
    go = 1'b1; run_all = ra; prog_sel = sel; cpu_done = stale;
    step();
    go = 1'b0; run_all = 1'($urandom); prog_sel = 2'($urandom);
    chk("err_clr", 32'(err), 0);
    foreach (progs[j]) begin
      int  p, w, e, cyc, k;
      bit  fire, seen;
      p = progs[j];
      w = 0;
      chk("launch_rise", 32'(cpu_start), 1);
      while (cpu_start === 1'b1 && w < 20) begin
        chk("pc_init",  32'(pc_init),  32'(base_ref[p]));
        chk("cur_prog", 32'(cur_prog), 32'(p));
        chk("busy",     32'(busy),     1);
        w++;
        step();
      end
      chk("launch_len", 32'(w), START);
      // reference: done ignored in RUN cycle 1, count saturates at 15
      e = stale ? 2 : (dly[j] < 2 ? 2 : dly[j]);
      fire = 1'b0;
`ifdef RUN_SEQ_WATCHDOG_EN
      if (e > SAT) begin e = SAT; fire = 1'b1; end
`endif
      cyc = (e < SAT) ? e : SAT;
      if (fire) exp_err = 1;
      seen = 1'b0;
      for (k = 1; k <= BUDGET; k++) begin
        if (cpu_start === 1'b1 || seq_done === 1'b1) begin
          seen = 1'b1;
          break;
        end
        cpu_done = stale || (k >= dly[j]);
        go = noise && (k < e) && ($urandom_range(0, 3) == 0);
        step();
      end
      go = 1'b0;
      if (!stale) cpu_done = 1'b0;
      if (e + 2 > BUDGET) begin
        chk("no_event", 32'(seen), 0);
        chk("still_busy", 32'(busy), 1);
        hung = 1'b1;
        return;
      end
      chk("event_seen", 32'(seen), 1);
      if (!seen) begin hung = 1'b1; return; end
      chk("event_latency", 32'(k), 32'(e + 2));
      chk("cycles", 32'(cycles), 32'(cyc));
      chk("err", 32'(err), 32'(exp_err));
      if (j == progs.size() - 1) begin
        chk("fin_seq_done", 32'(seq_done), 1);
        chk("fin_no_start", 32'(cpu_start), 0);
      end else begin
        chk("relaunch_no_done", 32'(seq_done), 0);
      end
    end
    cpu_done = 1'b0;
    step();
    chk("end_busy",     32'(busy),     0);
    chk("end_seq_done", 32'(seq_done), 0);
    chk("end_cur_prog", 32'(cur_prog), 32'(progs[progs.size() - 1]));
    repeat (3) begin
      step();
      chk("idle_start", 32'(cpu_start), 0);
      chk("idle_busy",  32'(busy),      0);
      chk("idle_err",   32'(err),       32'(exp_err));
    end
  endtask

  task automatic illegal_test();
    go = 1'b1; run_all = 1'b0; prog_sel = 2'd3;
    step();
    go = 1'b0;
    chk("ill_err",      32'(err),       1);
    chk("ill_seq_done", 32'(seq_done),  1);
    chk("ill_busy",     32'(busy),      0);
    chk("ill_start",    32'(cpu_start), 0);
    step();
    chk("ill_pulse_end", 32'(seq_done), 0);
    chk("ill_sticky",    32'(err),      1);
    chk("ill_no_start",  32'(cpu_start), 0);
  endtask

  // go while running is dropped; reset in RUN aborts with no seq_done
  task automatic abort_test();
    int n;
    go = 1'b1; run_all = 1'b0; prog_sel = 2'd0;
    step();
    go = 1'b0;
    n = 0;
    while (cpu_start === 1'b1 && n < 20) begin n++; step(); end
    chk("abort_launch_len", 32'(n), START);
    for (int i = 0; i < 5; i++) begin
      cpu_done = 1'b0; go = (i == 2); prog_sel = 2'd1;
      step();
      chk("abort_busy",    32'(busy),     1);
      chk("abort_no_done", 32'(seq_done), 0);
    end
    do_reset("abort");
  endtask

  initial begin
    int d3[3];
    bit hung;
    reset = 1'b0; go = 1'b0; run_all = 1'b0; prog_sel = 2'd0; cpu_done = 1'b0;
    step();
    step();
    reset_checks("rst");
    reset = 1'b1;
    step();
    chk("rst_rel_start", 32'(cpu_start), 0);

    d3 = '{10, 10, 10};
    session(1'b0, 2'd1, 1'b0, d3, 1'b0, hung);
    if (hung) do_reset("r1");
    d3 = '{5, 5, 5};
    session(1'b1, 2'd0, 1'b0, d3, 1'b1, hung);
    if (hung) do_reset("r2");
    session(1'b1, 2'd2, 1'b1, d3, 1'b0, hung);
    if (hung) do_reset("r3");
    illegal_test();
    d3 = '{20, 15, 16};
    session(1'b1, 2'd0, 1'b0, d3, 1'b0, hung);
    if (hung) do_reset("r4");
    d3 = '{NEVER, NEVER, NEVER};
    session(1'b0, 2'd2, 1'b0, d3, 1'b1, hung);
    if (hung) do_reset("r5");
    abort_test();

    for (int s = 0; s < 16; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        illegal_test();
      end else begin
        for (int i = 0; i < 3; i++)
          d3[i] = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 20));
        session(1'($urandom), 2'($urandom_range(0, 2)), $urandom_range(0, 5) == 0,
                d3, 1'b1, hung);
        if (hung) do_reset("rr");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
